// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and defaults for the instruction-memory arbiter.
//   owner_t    - who owns the response cycle of the access granted last cycle
//   AW_DEFAULT - default word-address width
package imem_arb_pkg;

  localparam int unsigned AW_DEFAULT = 30;
  localparam int unsigned DW         = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD_RD = 2'd2,
    OWN_LD_WR = 2'd3
  } owner_t;

endpackage

// File: rtl/imem_arb_age.sv
// imem_arb_age: saturating count of consecutive cycles the loader lost to fetch.
//   clk, rst : clock, async active-high reset
//   inc      : loader requested and lost this cycle
//   clr      : loader granted this cycle (has priority over inc)
//   at_max   : count has reached AGE_MAX, loader must win next contention
module imem_arb_age #(
  parameter int unsigned AGE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned AGEW = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);

  logic [AGEW-1:0] r_age;

  assign at_max = (r_age == AGEW'(AGE_MAX));

  // Saturating counter; a grant always wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age <= '0;
    end else if (clr) begin
      r_age <= '0;
    end else if (inc && !at_max) begin
      r_age <= r_age + AGEW'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between fetch and the
// UART loader. Fetch has priority; the age counter bounds loader starvation;
// boot gives the loader exclusive access.
//   fetch  : f_req, f_addr -> f_stall, f_valid, f_inst
//   loader : l_req, l_we, l_addr, l_wdata -> l_ack, l_rdata
//   memory : m_we, m_addr, m_wdata -> (registered address) -> m_rdata
// Grant is combinational; the response appears one cycle later, steered by owner.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned AGE_MAX = 4,
  parameter int unsigned AW      = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_stall,
  output logic          f_valid,
  output logic [DW-1:0] f_inst,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  owner_t        r_owner;
  owner_t        w_owner_nxt;
  logic [AW-1:0] r_addr_hold;
  logic          w_at_max;
  logic          w_l_win;
  logic          w_f_win;

  // Loader wins in boot, when alone, or once it has aged out.
  assign w_l_win = l_req & (boot | ~f_req | w_at_max);
  assign w_f_win = f_req & ~boot & ~w_l_win;

  imem_arb_age #(.AGE_MAX(AGE_MAX)) u_age (
    .clk    (clk),
    .rst    (rst),
    .inc    (l_req & ~w_l_win),
    .clr    (w_l_win),
    .at_max (w_at_max)
  );

  // Memory drive; the address holds its last value when nothing is granted.
  assign m_addr  = w_l_win ? l_addr : (w_f_win ? f_addr : r_addr_hold);
  assign m_we    = w_l_win & l_we;
  assign m_wdata = l_wdata;
  assign f_stall = f_req & ~w_f_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold <= '0;
    end else begin
      r_addr_hold <= m_addr;
    end
  end

  // Owner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Next owner from this cycle's winner.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_l_win) begin
      w_owner_nxt = l_we ? OWN_LD_WR : OWN_LD_RD;
    end else if (w_f_win) begin
      w_owner_nxt = OWN_FETCH;
    end
  end

  // Response steering for the access granted last cycle.
  always_comb begin
    f_valid = 1'b0;
    f_inst  = '0;
    l_ack   = 1'b0;
    l_rdata = '0;
    case (r_owner)
      OWN_FETCH: begin
        f_valid = 1'b1;
        f_inst  = m_rdata;
      end
      OWN_LD_RD: begin
        l_ack   = 1'b1;
        l_rdata = m_rdata;
      end
      OWN_LD_WR: begin
        l_ack   = 1'b1;
      end
      default: begin
        f_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int unsigned AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot, f_req, l_req, l_we;
  logic [AW-1:0] f_addr, l_addr, m_addr;
  logic [31:0]   l_wdata, f_inst, l_rdata, m_wdata, m_rdata;
  logic          f_stall, f_valid, l_ack, m_we;

  int n_vec = 0;
  int n_bad = 0;

  imem_arbiter #(.AGE_MAX(4), .AW(AW)) dut (
    .clk(clk), .rst(rst), .boot(boot),
    .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall), .f_valid(f_valid), .f_inst(f_inst),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered address, write on the same edge.
  logic [31:0] mem [256];
  logic [7:0]  r_ma = 8'd0;
  always @(posedge clk) begin
    if (m_we) mem[m_addr[7:0]] <= m_wdata;
    r_ma <= m_addr[7:0];
  end
  assign m_rdata = mem[r_ma];

  typedef struct {
    logic        b, fr, lr, lw;
    logic [29:0] fa, la;
    logic [31:0] lwd;
    logic        es, ewe, efv, eack;
    logic [29:0] ema;
    logic [31:0] efi, erd;
  } vec_t;

  vec_t vecs [64];
  int   n_rows = 0;

  task automatic row(input logic b, input logic fr, input logic [29:0] fa,
                     input logic lr, input logic lw, input logic [29:0] la, input logic [31:0] lwd,
                     input logic es, input logic [29:0] ema, input logic ewe,
                     input logic efv, input logic [31:0] efi, input logic eack, input logic [31:0] erd);
    vecs[n_rows].b = b;   vecs[n_rows].fr = fr; vecs[n_rows].fa = fa;
    vecs[n_rows].lr = lr; vecs[n_rows].lw = lw; vecs[n_rows].la = la; vecs[n_rows].lwd = lwd;
    vecs[n_rows].es = es; vecs[n_rows].ema = ema; vecs[n_rows].ewe = ewe;
    vecs[n_rows].efv = efv; vecs[n_rows].efi = efi;
    vecs[n_rows].eack = eack; vecs[n_rows].erd = erd;
    n_rows++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic fr, input logic [29:0] fa,
                       input logic lr, input logic lw, input logic [29:0] la, input logic [31:0] lwd);
    boot = b; f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_f_valid", {31'd0, f_valid}, 0);
    chk("reset_l_ack",   {31'd0, l_ack}, 0);
    chk("reset_m_addr",  {2'd0, m_addr}, 0);
    chk("reset_m_we",    {31'd0, m_we}, 0);
    tick(); tick();
    rst = 1'b0;

    // b fr fa  lr lw la  lwd  | es ema we fv finst ack rdata
    row(0,0,0,    0,0,0,    0,            0,0,    0, 0,0,            0,0);
    row(0,1,'h10, 0,0,0,    0,            0,'h10, 0, 0,0,            0,0);
    row(0,0,0,    0,0,0,    0,            0,'h10, 0, 1,32'h10000010, 0,0);
    row(0,0,0,    1,1,'h20, 32'h3c081f00, 0,'h20, 1, 0,0,            0,0);
    row(0,1,'h20, 0,0,0,    0,            0,'h20, 0, 0,0,            1,0);
    row(0,0,0,    0,0,0,    0,            0,'h20, 0, 1,32'h3c081f00, 0,0);
    row(0,0,0,    1,0,'h05, 0,            0,'h05, 0, 0,0,            0,0);
    row(0,0,0,    0,0,0,    0,            0,'h05, 0, 0,0,            1,32'h10000005);
    // Continuous contention: loader wins every 5th cycle.
    for (int i = 0; i < 10; i++) begin
      logic lw_now, lw_prev;
      lw_now  = (i % 5 == 4);
      lw_prev = (i > 0) && ((i - 1) % 5 == 4);
      row(0,1,'h30, 1,0,'h40, 0, lw_now, lw_now ? 30'h40 : 30'h30, 0,
          (i > 0) && !lw_prev, ((i > 0) && !lw_prev) ? 32'h10000030 : 32'h0,
          lw_prev, lw_prev ? 32'h10000040 : 32'h0);
    end
    // Boot: loader owns memory, fetch stalls throughout.
    for (int j = 0; j < 10; j++)
      row(1,1,'h30, 1,0,'h41, 0, 1,'h41, 0, 0,0, 1, (j == 0) ? 32'h10000040 : 32'h10000041);
    row(0,1,'h30, 1,0,'h41, 0,  0,'h30, 0, 0,0,            1,32'h10000041);
    row(1,1,'h50, 0,0,0,    0,  1,'h30, 0, 1,32'h10000030, 0,0);
    row(0,0,0,    0,0,0,    0,  0,'h30, 0, 0,0,            0,0);

    for (int i = 0; i < n_rows; i++) begin
      drive(vecs[i].b, vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].lwd);
      #2;
      n_vec++;
      if (f_stall !== vecs[i].es || m_addr !== vecs[i].ema || m_we !== vecs[i].ewe ||
          f_valid !== vecs[i].efv || f_inst !== vecs[i].efi ||
          l_ack !== vecs[i].eack || l_rdata !== vecs[i].erd) begin
        n_bad++;
        $display("FAIL row%0d: got stall=%b addr=%h we=%b fv=%b inst=%h ack=%b rd=%h expected stall=%b addr=%h we=%b fv=%b inst=%h ack=%b rd=%h",
                 i, f_stall, m_addr, m_we, f_valid, f_inst, l_ack, l_rdata,
                 vecs[i].es, vecs[i].ema, vecs[i].ewe, vecs[i].efv, vecs[i].efi, vecs[i].eack, vecs[i].erd);
      end
      tick();
    end

    // Age below max: fetch wins and age grows; lone loader then wins and clears age.
    drive(0, 0, 0, 1, 0, 'h01, 0); tick();
    drive(0, 1, 'h30, 1, 0, 'h40, 0); tick(); tick();
    chk("age_is_2", 32'(dut.u_age.r_age), 2);
    #1;
    chk("age2_fetch_wins", {2'd0, m_addr}, 'h30);
    chk("age2_no_stall", {31'd0, f_stall}, 0);
    tick();
    chk("age_is_3", 32'(dut.u_age.r_age), 3);
    drive(0, 0, 0, 1, 0, 'h40, 0);
    #1;
    chk("lone_loader_wins", {2'd0, m_addr}, 'h40);
    tick();
    chk("age_cleared", 32'(dut.u_age.r_age), 0);
    chk("lone_loader_ack", {31'd0, l_ack}, 1);

    // Reset in the cycle after a loader read grant loses the response.
    drive(0, 1, 'h30, 1, 0, 'h40, 0); tick();
    drive(0, 0, 0, 1, 0, 'h07, 0);
    #1;
    chk("rd_grant_addr", {2'd0, m_addr}, 'h07);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_l_ack", {31'd0, l_ack}, 0);
    chk("rst_mid_owner", 32'(dut.r_owner), 32'(OWN_NONE));
    chk("rst_mid_age", 32'(dut.u_age.r_age), 0);
    chk("rst_mid_m_addr", {2'd0, m_addr}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_l_ack", {31'd0, l_ack}, 0);
    chk("post_rst_f_valid", {31'd0, f_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
